// File: rtl/inst_buffer_pkg.sv
// Shared fetch/decode types and widths used by the instruction buffer.
package inst_buffer_pkg;

  localparam int unsigned INST_WIDTH      = 32;
  localparam int unsigned PC_WIDTH        = 32;
  localparam int unsigned INST_FETCH_NUM  = 4;
  localparam int unsigned INST_DECODE_NUM = 4;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and decode: whole-group enqueue,
// up to IB_DECODE_NUM oldest entries presented and popped per cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH      = 16,
  parameter int unsigned IB_DECODE_NUM = INST_DECODE_NUM,
  parameter int unsigned PTR_W         = $clog2(IB_DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  ib_entry_t [INST_FETCH_NUM-1:0]      insts_in,
  input  logic                                insts_in_valid,
  output logic                                stall,
  output ib_entry_t [IB_DECODE_NUM-1:0]       insts_out,
  output logic [IB_DECODE_NUM-1:0]            insts_out_valid,
  input  logic                                decode_ready
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(IB_DEPTH);
  localparam logic [PTR_W:0]   FETCH_CNT = (PTR_W+1)'(INST_FETCH_NUM);
  localparam logic [PTR_W:0]   DEC_CNT   = (PTR_W+1)'(IB_DECODE_NUM);
  localparam logic [PTR_W-1:0] FETCH_PTR = PTR_W'(INST_FETCH_NUM);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  ib_entry_t        entries [IB_DEPTH];

  logic [PTR_W:0]   free_slots;
  logic [PTR_W:0]   pop_n;
  logic [PTR_W:0]   count_next;
  logic             enq;
  logic             deq;

  // Stall looks only at registered occupancy; a same-cycle pop is not credited.
  always_comb begin
    free_slots = DEPTH_CNT - count;
    stall      = free_slots < FETCH_CNT;
    enq        = insts_in_valid & ~stall & ~flush;
    deq        = decode_ready & ~flush;
    pop_n      = (count < DEC_CNT) ? count : DEC_CNT;
    count_next = count;
    if (enq) count_next = count_next + FETCH_CNT;
    if (deq) count_next = count_next - pop_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + FETCH_PTR;
      if (deq) head <= head + pop_n[PTR_W-1:0];
      count <= count_next;
    end
  end

  // Storage is not reset; enq is already suppressed by flush.
  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      for (int unsigned i = 0; i < INST_FETCH_NUM; i++) begin
        entries[tail + PTR_W'(i)] <= insts_in[i];
      end
    end
  end

  always_comb begin
    insts_out       = '0;
    insts_out_valid = '0;
    for (int unsigned i = 0; i < IB_DECODE_NUM; i++) begin
      insts_out[i]       = entries[head + PTR_W'(i)];
      insts_out_valid[i] = (PTR_W+1)'(i) < count;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Instruction buffer bench: queue-based reference model, per-cycle compare,
// directed fill/stall/wrap/flush sequence followed by randomized traffic.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DEC   = 4;
  localparam int unsigned FN    = INST_FETCH_NUM;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          flush;
  ib_entry_t [FN-1:0]            insts_in;
  logic                          insts_in_valid;
  logic                          stall;
  ib_entry_t [DEC-1:0]           insts_out;
  logic [DEC-1:0]                insts_out_valid;
  logic                          decode_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          model_live = 1'b0;
  bit          allow_violation = 1'b0;
  ib_entry_t   q[$];

  inst_buffer #(.IB_DEPTH(DEPTH), .IB_DECODE_NUM(DEC)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .insts_in        (insts_in),
    .insts_in_valid  (insts_in_valid),
    .stall           (stall),
    .insts_out       (insts_out),
    .insts_out_valid (insts_out_valid),
    .decode_ready    (decode_ready)
  );

  always #5 clock = ~clock;

  function automatic bit model_stall();
    return (DEPTH - q.size()) < FN;
  endfunction

  // Advance the reference queue using the inputs present at the clock edge.
  task automatic model_update();
    bit st;
    int unsigned n;
    if (reset || flush) begin
      q.delete();
    end else begin
      st = model_stall();
      n  = (q.size() < DEC) ? q.size() : DEC;
      if (decode_ready) repeat (n) void'(q.pop_front());
      if (insts_in_valid && !st)
        for (int i = 0; i < FN; i++) q.push_back(insts_in[i]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    if (reset) model_live = 1'b1;
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] base, input bit dr, input bit fl);
    insts_in_valid = v;
    decode_ready   = dr;
    flush          = fl;
    for (int i = 0; i < FN; i++) begin
      insts_in[i].pc   = base + 32'(4 * i);
      insts_in[i].inst = $urandom;
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (model_live && !reset) begin
      logic [DEC-1:0] exp_v;
      exp_v = '0;
      for (int i = 0; i < DEC; i++) exp_v[i] = (i < q.size());
      check("stall", 64'(stall), 64'(model_stall()));
      check("valid", 64'(insts_out_valid), 64'(exp_v));
      for (int i = 0; i < DEC; i++)
        if (i < q.size()) check($sformatf("out[%0d]", i), 64'(insts_out[i]), 64'(q[i]));
      if (insts_in_valid && stall && !allow_violation)
        check("protocol_no_valid_while_stall", 64'(insts_in_valid & stall), 64'(0));
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_valid", 64'(insts_out_valid), 64'(0));

    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("empty_pop_valid", 64'(insts_out_valid), 64'(0));

    drive(1'b1, 32'h0, 1'b0, 1'b0); tick();
    check("fill_valid", 64'(insts_out_valid), 64'hf);
    check("fill_pc0", 64'(insts_out[0].pc), 64'h00);
    check("fill_pc3", 64'(insts_out[3].pc), 64'h0c);
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("drain_valid", 64'(insts_out_valid), 64'h0);

    for (int g = 1; g <= 4; g++) begin
      drive(1'b1, 32'(g * 16), 1'b0, 1'b0); tick();
    end
    check("full_stall", 64'(stall), 64'(1));
    check("full_pc0", 64'(insts_out[0].pc), 64'h10);

    allow_violation = 1'b1;
    drive(1'b1, 32'h900, 1'b0, 1'b0); tick();
    allow_violation = 1'b0;
    check("reject_stall", 64'(stall), 64'(1));
    check("reject_pc0", 64'(insts_out[0].pc), 64'h10);
    check("reject_pc3", 64'(insts_out[3].pc), 64'h1c);

    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("pop_unstall", 64'(stall), 64'(0));
    check("pop_pc0", 64'(insts_out[0].pc), 64'h20);

    drive(1'b1, 32'h100, 1'b1, 1'b0); tick();
    check("enqdeq_stall", 64'(stall), 64'(0));
    check("enqdeq_valid", 64'(insts_out_valid), 64'hf);
    check("enqdeq_pc0", 64'(insts_out[0].pc), 64'h30);

    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("wrap_pc0_a", 64'(insts_out[0].pc), 64'h40);
    tick();
    check("wrap_pc0_b", 64'(insts_out[0].pc), 64'h100);
    check("wrap_pc3_b", 64'(insts_out[3].pc), 64'h10c);

    drive(1'b1, 32'h200, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h300, 1'b1, 1'b1); tick();
    check("flush_valid", 64'(insts_out_valid), 64'h0);
    check("flush_stall", 64'(stall), 64'(0));
    drive(1'b1, 32'h400, 1'b0, 1'b0); tick();
    check("post_flush_pc0", 64'(insts_out[0].pc), 64'h400);
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("post_flush_drain", 64'(insts_out_valid), 64'h0);

    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 2) != 0) && !model_stall(), $urandom & 32'hffff_fff0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 300) == 0);
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
